// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_tick_div.sv
// Prescaler: emits one tick every TICK_DIV enabled cycles; holds its phase while en is low.
module bcd_tick_div #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_reg;

    // With TICK_DIV = 1 the counter sits at 0 == LAST, so tick degenerates to en.
    assign tick = en && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable two-digit BCD countdown timer with start/pause, prescaler, optional auto-reload.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val1,
    input  logic [3:0] load_val0,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] count1,
    output logic [3:0] count0,
    output logic       busy,
    output logic       done,
    output logic       load_err
);

    state_t     state_reg, state_next;
    logic [3:0] count1_reg, count1_next, count0_reg, count0_next;
    logic [3:0] reload1_reg, reload1_next, reload0_reg, reload0_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       div_clr, div_en, tick;

    logic load_ok, count_zero, count_one, reload_zero;
    assign load_ok     = is_bcd(load_val1) && is_bcd(load_val0);
    assign count_zero  = (count1_reg == BCD_ZERO) && (count0_reg == BCD_ZERO);
    assign count_one   = (count1_reg == BCD_ZERO) && (count0_reg == 4'd1);
    assign reload_zero = (reload1_reg == BCD_ZERO) && (reload0_reg == BCD_ZERO);

    // A pending load or pause freezes the prescaler phase, so a coincident tick is dropped.
    assign div_en = (state_reg == RUN) && !load && !pause;

    bcd_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count1_reg  <= BCD_ZERO;
            count0_reg  <= BCD_ZERO;
            reload1_reg <= BCD_ZERO;
            reload0_reg <= BCD_ZERO;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count1_reg  <= count1_next;
            count0_reg  <= count0_next;
            reload1_reg <= reload1_next;
            reload0_reg <= reload0_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count1_next  = count1_reg;
        count0_next  = count0_reg;
        reload1_next = reload1_reg;
        reload0_next = reload0_reg;
        done_next    = 1'b0;
        err_next     = err_reg;
        div_clr      = 1'b0;
        if (load) begin
            if (load_ok) begin
                count1_next  = load_val1;
                count0_next  = load_val0;
                reload1_next = load_val1;
                reload0_next = load_val0;
                err_next     = 1'b0;
                div_clr      = 1'b1;
                state_next   = IDLE;
            end else begin
                err_next = 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !pause && !count_zero) begin
                        state_next = RUN;
                        div_clr    = 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick) begin
                        if (count_one) begin
                            done_next = 1'b1;
                            if (AUTO_RELOAD && !reload_zero) begin
                                count1_next = reload1_reg;
                                count0_next = reload0_reg;
                            end else begin
                                count1_next = BCD_ZERO;
                                count0_next = BCD_ZERO;
                                state_next  = DONE;
                            end
                        end else if (count0_reg == BCD_ZERO) begin
                            count0_next = BCD_MAX;
                            count1_next = count1_reg - 4'd1;
                        end else begin
                            count0_next = count0_reg - 4'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_next = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state_reg == RUN);
        done     = done_reg;
        load_err = err_reg;
        count1   = count1_reg;
        count0   = count0_reg;
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer across three parameterisations sharing one stimulus bus.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       rst, load, start, pause;
    logic [3:0] load_val1, load_val0;
    logic [2:0][3:0] c1, c0;
    logic [2:0] busy, done, err;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       err;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: TICK_DIV=1 stop; dut1: TICK_DIV=4 stop; dut2: TICK_DIV=1 auto-reload
    bcd_down_timer #(.TICK_DIV(1), .AUTO_RELOAD(1'b0)) u0 (
        .clk(clk), .rst(rst), .load(load), .load_val1(load_val1), .load_val0(load_val0),
        .start(start), .pause(pause), .count1(c1[0]), .count0(c0[0]),
        .busy(busy[0]), .done(done[0]), .load_err(err[0]));
    bcd_down_timer #(.TICK_DIV(4), .AUTO_RELOAD(1'b0)) u1 (
        .clk(clk), .rst(rst), .load(load), .load_val1(load_val1), .load_val0(load_val0),
        .start(start), .pause(pause), .count1(c1[1]), .count0(c0[1]),
        .busy(busy[1]), .done(done[1]), .load_err(err[1]));
    bcd_down_timer #(.TICK_DIV(1), .AUTO_RELOAD(1'b1)) u2 (
        .clk(clk), .rst(rst), .load(load), .load_val1(load_val1), .load_val0(load_val0),
        .start(start), .pause(pause), .count1(c1[2]), .count0(c0[2]),
        .busy(busy[2]), .done(done[2]), .load_err(err[2]));

    // Monitor: one line per checked transaction
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                got = {c1[e.dut], c0[e.dut]};
                if (e.cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: stale entry cyc=%0d now=%0d", e.tag, e.cyc, cyc);
                end else if (got !== e.cnt || busy[e.dut] !== e.busy ||
                             done[e.dut] !== e.done || err[e.dut] !== e.err) begin
                    bad++;
                    $display("FAIL %s dut%0d cyc=%0d got cnt=%h busy=%b done=%b err=%b want cnt=%h busy=%b done=%b err=%b",
                             e.tag, e.dut, cyc, got, busy[e.dut], done[e.dut], err[e.dut],
                             e.cnt, e.busy, e.done, e.err);
                end else begin
                    $display("ok   %s dut%0d cyc=%0d cnt=%h busy=%b done=%b err=%b",
                             e.tag, e.dut, cyc, got, busy[e.dut], done[e.dut], err[e.dut]);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic l, input logic [3:0] v1, input logic [3:0] v0,
                         input logic s, input logic p);
        rst = r; load = l; load_val1 = v1; load_val0 = v0; start = s; pause = p;
    endtask

    task automatic ex(input int d, input logic [7:0] c, input logic b, input logic dn,
                      input logic er, input string tag);
        exp_t e;
        e.cyc = cyc + 1; e.dut = d; e.cnt = c; e.busy = b; e.done = dn; e.err = er; e.tag = tag;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs, expect the post-edge outputs of one DUT.
    task automatic st(input logic r, input logic l, input logic [3:0] v1, input logic [3:0] v0,
                      input logic s, input logic p, input int d, input logic [7:0] c,
                      input logic b, input logic dn, input logic er, input string tag);
        drive(r, l, v1, v0, s, p);
        ex(d, c, b, dn, er, tag);
        @(negedge clk);
    endtask

    task automatic idle(input int d, input logic [7:0] c, input logic b, input logic dn,
                        input logic er, input string tag);
        st(0, 0, 0, 0, 0, 0, d, c, b, dn, er, tag);
    endtask

    task automatic reset_all();
        drive(1, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) ex(d, 8'h00, 0, 0, 0, "reset");
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_all();

        // TICK_DIV=1 count sequence from 23
        st(0, 1, 4'd2, 4'd3, 0, 0, 0, 8'h23, 0, 0, 0, "load23");
        st(0, 0, 0, 0, 1, 0, 0, 8'h23, 1, 0, 0, "start23");
        idle(0, 8'h22, 1, 0, 0, "dec22");
        idle(0, 8'h21, 1, 0, 0, "dec21");
        idle(0, 8'h20, 1, 0, 0, "dec20");
        idle(0, 8'h19, 1, 0, 0, "borrow19");
        idle(0, 8'h18, 1, 0, 0, "dec18");

        // Expiry from 01 without reload
        st(0, 1, 4'd0, 4'd1, 0, 0, 0, 8'h01, 0, 0, 0, "load01");
        st(0, 0, 0, 0, 1, 0, 0, 8'h01, 1, 0, 0, "start01");
        idle(0, 8'h00, 0, 1, 0, "expire");
        idle(0, 8'h00, 0, 0, 0, "done_one_cycle");
        st(0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, "start_in_done");
        idle(0, 8'h00, 0, 0, 0, "done_holds");

        // TICK_DIV=4 with pause at phase 0 and mid-phase
        reset_all();
        st(0, 1, 4'd1, 4'd0, 0, 0, 1, 8'h10, 0, 0, 0, "load10");
        st(0, 0, 0, 0, 1, 0, 1, 8'h10, 1, 0, 0, "start10");
        for (int i = 0; i < 3; i++) idle(1, 8'h10, 1, 0, 0, "presc_hold");
        idle(1, 8'h09, 1, 0, 0, "first_tick");
        for (int i = 0; i < 10; i++) st(0, 0, 0, 0, 0, 1, 1, 8'h09, 0, 0, 0, "paused");
        st(0, 0, 0, 0, 1, 0, 1, 8'h09, 1, 0, 0, "resume");
        for (int i = 0; i < 3; i++) idle(1, 8'h09, 1, 0, 0, "resume_hold");
        idle(1, 8'h08, 1, 0, 0, "resume_tick");
        for (int i = 0; i < 2; i++) idle(1, 8'h08, 1, 0, 0, "phase_adv");
        for (int i = 0; i < 3; i++) st(0, 0, 0, 0, 0, 1, 1, 8'h08, 0, 0, 0, "pause_mid");
        st(0, 0, 0, 0, 1, 0, 1, 8'h08, 1, 0, 0, "resume_mid");
        idle(1, 8'h08, 1, 0, 0, "phase3");
        idle(1, 8'h07, 1, 0, 0, "held_phase_tick");

        // Auto-reload from 03
        reset_all();
        st(0, 1, 4'd0, 4'd3, 0, 0, 2, 8'h03, 0, 0, 0, "ar_load03");
        st(0, 0, 0, 0, 1, 0, 2, 8'h03, 1, 0, 0, "ar_start");
        idle(2, 8'h02, 1, 0, 0, "ar02");
        idle(2, 8'h01, 1, 0, 0, "ar01");
        idle(2, 8'h03, 1, 1, 0, "ar_reload");
        idle(2, 8'h02, 1, 0, 0, "ar02b");
        idle(2, 8'h01, 1, 0, 0, "ar01b");
        idle(2, 8'h03, 1, 1, 0, "ar_reload2");
        idle(2, 8'h02, 1, 0, 0, "ar02c");

        // Invalid load keeps count, sets sticky error
        reset_all();
        st(0, 1, 4'd4, 4'd2, 0, 0, 0, 8'h42, 0, 0, 0, "load42");
        st(0, 1, 4'hA, 4'd5, 0, 0, 0, 8'h42, 0, 0, 1, "bad_loadA5");
        idle(0, 8'h42, 0, 0, 1, "err_sticky");
        st(0, 1, 4'd0, 4'd7, 0, 0, 0, 8'h07, 0, 0, 0, "load07");

        // Reset mid-run
        st(0, 1, 4'd5, 4'd8, 0, 0, 0, 8'h58, 0, 0, 0, "load58");
        st(0, 0, 0, 0, 1, 0, 0, 8'h58, 1, 0, 0, "start58");
        st(0, 1, 4'hF, 4'hF, 0, 0, 0, 8'h58, 1, 0, 1, "bad_load_run");
        idle(0, 8'h57, 1, 0, 1, "run57");
        st(1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, "rst_midrun");
        st(0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, "start_after_rst");
        idle(0, 8'h00, 0, 0, 0, "idle_after_rst");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Loadable two-digit BCD countdown timer, 99 down to 00; the down-counting counterpart of the team's 0-99 BCD up counter.
- Used wherever the design needs a decimal countdown with a terminal pulse, such as display timers or timeouts.
- Adds start/pause control, a tick prescaler, optional auto-reload and a one-cycle done pulse.

Parameters:
- TICK_DIV, 1: clock cycles per decrement while running; legal range 1..65535.
- AUTO_RELOAD, 0: 0 = stop at 00 on expiry; 1 = reload the last loaded value on expiry and keep running.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load request for load_val1/load_val0.
- load_val1  input  4  tens digit to load (BCD).
- load_val0  input  4  units digit to load (BCD).
- start  input  1  start or resume counting.
- pause  input  1  suspend counting.
- count1  output  4  tens digit (registered).
- count0  output  4  units digit (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on expiry.
- load_err  output  1  sticky flag: last load attempt had a non-BCD digit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count1 = count0 = 0; reload register = 00; prescaler = 0.
  - State IDLE; busy = 0, done = 0, load_err = 0.
  - rst overrides every other input.
- States: IDLE, RUN, PAUSED, DONE. busy = (state == RUN). done is registered and defaults to 0 every cycle.
- Input priority, highest first: rst > load > pause > start.
- load, any state:
  - Valid (both digits <= 9): count <= load value; reload register <= load value; prescaler <= 0; load_err <= 0; state <= IDLE.
  - Invalid (either digit > 9): counts, reload register and state unchanged; load_err <= 1.
- IDLE:
  - start with count != 00 -> RUN, prescaler <= 0.
  - start with count == 00 is ignored: stays IDLE, no done pulse.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. A tick occurs on the cycle where prescaler == TICK_DIV-1, and the prescaler wraps to 0.
  - With TICK_DIV = 1, every RUN cycle is a tick.
  - Start latency: start sampled at edge N enters RUN; the first decrement is at edge N+TICK_DIV.
  - Decrement on tick:
    - count0 != 0: count0 <= count0 - 1.
    - count0 == 0: count0 <= 9 and count1 <= count1 - 1.
  - Expiry is a tick while count == 01:
    - AUTO_RELOAD = 0: count <= 00; done <= 1 on the same edge; state <= DONE.
    - AUTO_RELOAD = 1 and reload != 00: count <= reload value (00 is never displayed); done <= 1; state stays RUN.
    - AUTO_RELOAD = 1 and reload == 00: behaves as AUTO_RELOAD = 0.
  - pause -> PAUSED; prescaler and counts hold; a tick due on the same cycle is not applied.
- PAUSED: start (without pause) -> RUN; the prescaler resumes from its held value.
- DONE: count holds 00; start is ignored; only a valid load leaves DONE (to IDLE).
- Digits never leave 0..9. An underflow below 00 is impossible by construction.
- rst asserted mid-run clears everything within one edge; done does not pulse.

Decomposition:
- Shared package bcd_pkg:
  - state enum: IDLE, RUN, PAUSED, DONE.
  - constants BCD_MAX = 4'd9 and BCD_ZERO = 4'd0.
  - function is_bcd(digit), returns digit <= BCD_MAX.
- Sub-module bcd_tick_div:
  - Parameterised prescaler with inputs clk, rst, clr, en; output tick.
  - Prescaler width = $clog2(TICK_DIV) with a minimum of 1.
  - When TICK_DIV = 1, tick = en.

Test Plan:
- Reset, load 2/3, start, TICK_DIV=1 -> count sequence 23, 22, 21, 20, 19 …; busy=1 from the cycle after start.
- Load 0/1, start, AUTO_RELOAD=0 -> after one cycle count=00, done=1 for exactly one cycle, busy=0, state DONE; a further start leaves count at 00.
- TICK_DIV=4, load 1/0, start, then pause for 10 cycles after the first decrement, then start -> 10 -> 09 after 4 cycles; the value holds at 09 while paused; the next decrement lands 4 tick-cycles after resume, counting the prescaler's held phase.
- AUTO_RELOAD=1, load 0/3, start -> 03, 02, 01, 03, 02 …; done pulses on every transition from 01 to 03; 00 never appears.
- Load A/5 (invalid tens digit) after a valid load of 4/2 -> count stays 42, load_err=1; a subsequent valid load of 0/7 -> count=07, load_err=0.
- rst asserted during RUN at count 57 -> next edge: count=00, busy=0, done=0, load_err=0; start afterwards is ignored because count is 00.
